// File: rtl/sprite_layer.sv
// sprite_layer: pipelined single-sprite overlay for the VGA colour path.
//
// Places one palette-indexed sprite at a runtime position with a runtime
// power-of-two magnification, keys out one transparent palette index over
// the incoming background colour, and steps through animation frames that
// are stored back-to-back in an external synchronous sprite ROM.
//
// Ports:
//   vga_clk, reset_n            pixel clock, synchronous active-low reset
//   DrawX, DrawY, blank         current pixel coordinates, 1 = active video
//   pos_x, pos_y, scale         sprite top-left and log2 magnification,
//                               taken only at frame start (pixel 0,0)
//   anim_en                     allows the animation counters to advance
//   bg_red/green/blue           background colour aligned with DrawX/DrawY
//   rom_addr / rom_q            registered ROM address / ROM data one cycle later
//   pal_index / pal_*           index to the external combinational palette
//   red/green/blue, hit         registered pixel colour and in-box flag,
//                               three cycles behind the coordinate inputs
module sprite_layer #(
  parameter int SPR_W      = 55,
  parameter int SPR_H      = 55,
  parameter int FRAMES     = 1,
  parameter int HOLD       = 8,
  parameter int IDX_W      = 2,
  parameter int TRANSP_IDX = 0,
  parameter int ADDR_W     = $clog2(SPR_W*SPR_H*FRAMES)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        pos_x,
  input  logic [9:0]        pos_y,
  input  logic [1:0]        scale,
  input  logic              anim_en,
  input  logic [3:0]        bg_red,
  input  logic [3:0]        bg_green,
  input  logic [3:0]        bg_blue,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        pal_red,
  input  logic [3:0]        pal_green,
  input  logic [3:0]        pal_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              hit
);

  localparam int FRM_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [FRM_W-1:0]  LAST_FRAME = FRM_W'(FRAMES - 1);
  localparam logic [HOLD_W-1:0] LAST_HOLD  = HOLD_W'(HOLD - 1);
  localparam logic [IDX_W-1:0]  TRANSP     = IDX_W'(TRANSP_IDX);

  // Frame-start shadows and animation state
  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic [1:0]        scale_q, scale_d;
  logic [FRM_W-1:0]  animFrame_q, animFrame_d;
  logic [HOLD_W-1:0] holdCnt_q, holdCnt_d;

  // Pipeline registers
  logic [ADDR_W-1:0] romAddr_q, romAddr_d;
  logic              hit1_q, hit1_d, blank1_q, blank1_d;
  logic [11:0]       bg1_q, bg1_d;
  logic              hit2_q, blank2_q;
  logic [11:0]       bg2_q;
  logic [11:0]       rgb_q, rgb_d;
  logic              hit_q;

  logic              frameStart;
  logic [12:0]       x13, y13, sx13, sy13, extW, extH, dx, dy, u, v;
  logic              inBox;

  // Shadows and animation counters only move on the frame-start pixel; that
  // pixel is still rendered from the old values because stage 0 reads the
  // registered shadows, not the raw inputs.
  always_comb begin
    frameStart  = (DrawX == 10'd0) && (DrawY == 10'd0);
    sx_d        = sx_q;
    sy_d        = sy_q;
    scale_d     = scale_q;
    animFrame_d = animFrame_q;
    holdCnt_d   = holdCnt_q;
    if (frameStart) begin
      sx_d    = pos_x;
      sy_d    = pos_y;
      scale_d = scale;
      if (anim_en) begin
        if (holdCnt_q == LAST_HOLD) begin
          holdCnt_d   = '0;
          animFrame_d = (animFrame_q == LAST_FRAME) ? '0 : animFrame_q + 1'b1;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end
    end
  end

  // Stage 0: box test and texel address. Everything is widened to 13 bits
  // so sx + extent never wraps, which makes the box clip at the screen edge.
  always_comb begin
    x13   = 13'(DrawX);
    y13   = 13'(DrawY);
    sx13  = 13'(sx_q);
    sy13  = 13'(sy_q);
    extW  = 13'(SPR_W) << scale_q;
    extH  = 13'(SPR_H) << scale_q;
    inBox = blank && (x13 >= sx13) && (x13 < sx13 + extW)
                  && (y13 >= sy13) && (y13 < sy13 + extH);
    dx    = x13 - sx13;
    dy    = y13 - sy13;
    u     = dx >> scale_q;
    v     = dy >> scale_q;
    romAddr_d = '0;
    if (inBox) begin
      romAddr_d = ADDR_W'(animFrame_q) * ADDR_W'(SPR_W*SPR_H)
                + ADDR_W'(v) * ADDR_W'(SPR_W) + ADDR_W'(u);
    end
    hit1_d   = inBox;
    blank1_d = blank;
    bg1_d    = {bg_red, bg_green, bg_blue};
  end

  // Output select: rom_q is valid during stage 2, so the palette lookup and
  // transparency key are resolved straight into the output register.
  always_comb begin
    if (!blank2_q) begin
      rgb_d = 12'h000;
    end else if (hit2_q && (rom_q != TRANSP)) begin
      rgb_d = {pal_red, pal_green, pal_blue};
    end else begin
      rgb_d = bg2_q;
    end
  end

  // All state, including every pipeline stage, clears on reset so the
  // outputs stay black until real pixels have flowed through.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      scale_q     <= '0;
      animFrame_q <= '0;
      holdCnt_q   <= '0;
      romAddr_q   <= '0;
      hit1_q      <= 1'b0;
      blank1_q    <= 1'b0;
      bg1_q       <= '0;
      hit2_q      <= 1'b0;
      blank2_q    <= 1'b0;
      bg2_q       <= '0;
      rgb_q       <= '0;
      hit_q       <= 1'b0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      scale_q     <= scale_d;
      animFrame_q <= animFrame_d;
      holdCnt_q   <= holdCnt_d;
      romAddr_q   <= romAddr_d;
      hit1_q      <= hit1_d;
      blank1_q    <= blank1_d;
      bg1_q       <= bg1_d;
      hit2_q      <= hit1_q;
      blank2_q    <= blank1_q;
      bg2_q       <= bg1_q;
      rgb_q       <= rgb_d;
      hit_q       <= hit2_q;
    end
  end

  assign rom_addr  = romAddr_q;
  assign pal_index = rom_q;
  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign hit       = hit_q;

endmodule

// File: tb/tb_sprite_layer.sv
// tb_sprite_layer: directed-vector scoreboard bench for sprite_layer.
// Stimulus pushes hand-computed expectations into due-ordered queues; a
// monitor on the falling edge pops and compares whatever is due that cycle.
module tb_sprite_layer;

  localparam logic [11:0] BG   = 12'h333;
  localparam logic [11:0] PAL1 = 12'h95D;
  localparam logic [11:0] PAL2 = 12'hA6E;
  localparam logic [11:0] PAL3 = 12'hB7F;
  localparam logic [11:0] BLK  = 12'h000;

  logic        vga_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic        blank = 1'b0;
  logic [9:0]  pos_x = '0, pos_y = '0;
  logic [1:0]  scale = '0;
  logic        anim_en = 1'b0;
  logic [3:0]  bg_red = 4'h3, bg_green = 4'h3, bg_blue = 4'h3;
  logic [13:0] rom_addr;
  logic [1:0]  rom_q;
  logic [1:0]  pal_index;
  logic [3:0]  pal_red, pal_green, pal_blue;
  logic [3:0]  red, green, blue;
  logic        hit;

  logic        romConstEn = 1'b0;
  logic [1:0]  romConst = 2'd0;

  int cyc = 0;
  int tests = 0;
  int failed = 0;

  typedef struct {
    int          due;
    string       name;
    logic [13:0] addr;
    logic        hit;
    logic [11:0] rgb;
  } exp_t;

  exp_t addrQ[$];
  exp_t outQ[$];
  exp_t ma, mo;

  int          animAddr[12] = '{1, 3026, 3026, 6051, 6051, 1, 1, 3026, 3026, 3026, 3026, 6051};
  logic [11:0] animRgb[12]  = '{PAL1, PAL2, PAL2, PAL3, PAL3, PAL1, PAL1, PAL2, PAL2, PAL2, PAL2, PAL3};
  bit          animEn[12]   = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};

  sprite_layer #(
    .SPR_W(55), .SPR_H(55), .FRAMES(3), .HOLD(2), .IDX_W(2), .TRANSP_IDX(0)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n),
    .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .anim_en(anim_en),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .red(red), .green(green), .blue(blue), .hit(hit)
  );

  always #5 vga_clk = ~vga_clk;

  always @(posedge vga_clk) cyc <= cyc + 1;

  // Synchronous ROM: index is the low address bits unless forced constant
  always @(posedge vga_clk) rom_q <= romConstEn ? romConst : rom_addr[1:0];

  // Combinational palette with distinct per-channel values
  assign pal_red   = 4'h8 + {2'b00, pal_index};
  assign pal_green = 4'h4 + {2'b00, pal_index};
  assign pal_blue  = 4'hC + {2'b00, pal_index};

  task automatic checkAddr(input string name, input int delay, input logic [13:0] a);
    exp_t e;
    int   idx;
    e.due = cyc + delay; e.name = name; e.addr = a; e.hit = 1'b0; e.rgb = '0;
    idx = addrQ.size();
    while (idx > 0 && addrQ[idx-1].due > e.due) idx--;
    addrQ.insert(idx, e);
  endtask

  task automatic checkOutput(input string name, input int delay, input logic h,
                             input logic [11:0] rgb);
    exp_t e;
    int   idx;
    e.due = cyc + delay; e.name = name; e.addr = '0; e.hit = h; e.rgb = rgb;
    idx = outQ.size();
    while (idx > 0 && outQ[idx-1].due > e.due) idx--;
    outQ.insert(idx, e);
  endtask

  task automatic applyStimulus(input string name, input int x, input int y, input bit bl,
                               input bit chk, input int expAddr, input bit expHit,
                               input logic [11:0] expRgb);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = bl;
    if (chk) begin
      checkAddr(name, 1, 14'(expAddr));
      checkOutput(name, 3, expHit, expRgb);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus("idle", 1000, 1000, 0, 0, 0, 0, BLK);
  endtask

  // Monitor: compare everything due this cycle
  always @(negedge vga_clk) begin
    while (addrQ.size() > 0 && addrQ[0].due <= cyc) begin
      ma = addrQ.pop_front();
      tests++;
      if (ma.due != cyc) begin
        failed++;
        $display("[TB] FAIL %s rom_addr: slot %0d missed at cycle %0d", ma.name, ma.due, cyc);
      end else if (rom_addr !== ma.addr) begin
        failed++;
        $display("[TB] FAIL %s rom_addr: got %0d expected %0d", ma.name, rom_addr, ma.addr);
      end
    end
    while (outQ.size() > 0 && outQ[0].due <= cyc) begin
      mo = outQ.pop_front();
      tests++;
      if (mo.due != cyc) begin
        failed++;
        $display("[TB] FAIL %s pixel: slot %0d missed at cycle %0d", mo.name, mo.due, cyc);
      end else if (hit !== mo.hit || {red, green, blue} !== mo.rgb) begin
        failed++;
        $display("[TB] FAIL %s pixel: got hit=%0b rgb=%03h expected hit=%0b rgb=%03h",
                 mo.name, hit, {red, green, blue}, mo.hit, mo.rgb);
      end
    end
  end

  initial begin
    // Reset with random inputs; outputs must be zero after each reset edge
    for (int i = 0; i < 4; i++) begin
      @(negedge vga_clk);
      reset_n  = 1'b0;
      DrawX    = 10'($urandom_range(0, 1023));
      DrawY    = 10'($urandom_range(0, 1023));
      blank    = 1'($urandom_range(0, 1));
      pos_x    = 10'($urandom_range(0, 1023));
      pos_y    = 10'($urandom_range(0, 1023));
      scale    = 2'($urandom_range(0, 3));
      anim_en  = 1'($urandom_range(0, 1));
      bg_red   = 4'($urandom_range(0, 15));
      bg_green = 4'($urandom_range(0, 15));
      bg_blue  = 4'($urandom_range(0, 15));
      checkAddr("reset", 1, 14'd0);
      checkOutput("reset", 1, 1'b0, BLK);
    end
    pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0; anim_en = 1'b0;
    bg_red = 4'h3; bg_green = 4'h3; bg_blue = 4'h3;
    for (int i = 0; i < 3; i++) begin
      applyStimulus("post-reset", 1000, 1000, 0, 1, 0, 0, BLK);
      if (i == 0) reset_n = 1'b1;
      checkOutput("post-reset-flush", 1, 1'b0, BLK);
    end

    // Placement at (100,50), scale 0
    applyStimulus("fs-place", 0, 0, 0, 0, 0, 0, BLK);
    applyStimulus("place-99-50",   99,  50, 1, 1, 0,    0, BG);
    applyStimulus("place-100-50",  100, 50, 1, 1, 0,    1, BG);
    applyStimulus("place-101-51",  101, 51, 1, 1, 56,   1, BG);
    applyStimulus("place-102-50",  102, 50, 1, 1, 2,    1, PAL2);
    applyStimulus("place-103-50",  103, 50, 1, 1, 3,    1, PAL3);
    applyStimulus("place-154-50",  154, 50, 1, 1, 54,   1, PAL2);
    applyStimulus("place-155-50",  155, 50, 1, 1, 0,    0, BG);
    applyStimulus("place-100-104", 100, 104, 1, 1, 2970, 1, PAL2);
    applyStimulus("place-100-105", 100, 105, 1, 1, 0,    0, BG);
    applyStimulus("place-blank0",  120, 60, 0, 1, 0,    0, BLK);

    // Transparency with a constant ROM
    idle(4);
    romConstEn = 1'b1; romConst = 2'd0;
    applyStimulus("transp-idx0", 110, 60, 1, 1, 560, 1, BG);
    idle(4);
    romConst = 2'd2;
    applyStimulus("transp-idx2", 110, 60, 1, 1, 560, 1, PAL2);
    idle(4);
    romConstEn = 1'b0;

    // Scale 2 at (0,0)
    pos_x = 10'd0; pos_y = 10'd0; scale = 2'd2;
    applyStimulus("fs-s2", 0, 0, 0, 0, 0, 0, BLK);
    applyStimulus("s2-3-0",   3,   0, 1, 1, 0,  1, BG);
    applyStimulus("s2-4-0",   4,   0, 1, 1, 1,  1, PAL1);
    applyStimulus("s2-219-0", 219, 0, 1, 1, 54, 1, PAL2);
    applyStimulus("s2-220-0", 220, 0, 1, 1, 0,  0, BG);
    applyStimulus("s2-8-5",   8,   5, 1, 1, 57, 1, PAL1);

    // Clip at the right edge; pixel (0,0) still uses the old shadows
    pos_x = 10'd600;
    applyStimulus("fs-clip-old", 0, 0, 1, 1, 0, 1, BG);
    applyStimulus("clip-599-0", 599, 0, 1, 1, 0, 0, BG);
    applyStimulus("clip-600-0", 600, 0, 1, 1, 0, 1, BG);
    applyStimulus("clip-639-0", 639, 0, 1, 1, 9, 1, PAL1);
    applyStimulus("clip-5-1",   5,   1, 1, 1, 0, 0, BG);

    // Mid-frame position change is ignored until the next frame start
    pos_x = 10'd100; pos_y = 10'd50; scale = 2'd0;
    applyStimulus("fs-mid", 0, 0, 1, 1, 0, 0, BG);
    applyStimulus("mid-100-100", 100, 100, 1, 1, 2750, 1, PAL2);
    pos_x = 10'd200;
    applyStimulus("mid-200-101", 200, 101, 1, 1, 0,    0, BG);
    applyStimulus("mid-120-101", 120, 101, 1, 1, 2825, 1, PAL1);
    applyStimulus("fs-next", 0, 0, 1, 1, 0, 0, BG);
    applyStimulus("next-200-50", 200, 50, 1, 1, 0, 1, BG);
    applyStimulus("next-201-50", 201, 50, 1, 1, 1, 1, PAL1);
    applyStimulus("next-100-50", 100, 50, 1, 1, 0, 0, BG);

    // Animation: base 0,0,3025,3025,6050,6050,0,... with a freeze
    pos_x = 10'd100; anim_en = 1'b0;
    applyStimulus("fs-anim0", 0, 0, 0, 0, 0, 0, BLK);
    applyStimulus("anim-base0", 101, 50, 1, 1, 1, 1, PAL1);
    for (int i = 0; i < 12; i++) begin
      anim_en = animEn[i];
      applyStimulus("fs-anim", 0, 0, 0, 0, 0, 0, BLK);
      applyStimulus($sformatf("anim-%0d", i), 101, 50, 1, 1, animAddr[i], 1, animRgb[i]);
    end
    anim_en = 1'b0;
    applyStimulus("anim-blank0", 110, 60, 0, 1, 0, 0, BLK);
    idle(5);

    // Drain with a bound
    for (int i = 0; i < 20 && (addrQ.size() > 0 || outQ.size() > 0); i++) @(negedge vga_clk);
    if (addrQ.size() > 0 || outQ.size() > 0) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", addrQ.size() + outQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sprite_layer.md
# sprite_layer

Pipelined single-sprite overlay for the VGA path. It is the parametrised successor to the full-screen stretched sprite drawer. It places one palette-indexed sprite at a runtime position with a runtime power-of-two scale, treats one palette index as transparent over a background colour stream, and cycles animation frames stored back-to-back in the sprite ROM. It sits between the background/board renderer and the VGA colour outputs; the synchronous sprite ROM and the combinational palette are external.

## Interface
- SPR_W, 55, sprite width in texels
- SPR_H, 55, sprite height in texels
- FRAMES, 1, animation frames stored consecutively in ROM
- HOLD, 8, video frames each animation frame is shown
- IDX_W, 2, palette index width
- TRANSP_IDX, 0, palette index treated as transparent
- ADDR_W, $clog2(SPR_W*SPR_H*FRAMES), ROM address width
- vga_clk  in  1  pixel clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- DrawX, DrawY  in  10 each  current pixel coordinates
- blank  in  1  1 = active video
- pos_x, pos_y  in  10 each  sprite top-left; sampled at frame start
- scale  in  2  magnification 1<<scale (1,2,4,8); sampled at frame start
- anim_en  in  1  enables animation advance
- bg_red, bg_green, bg_blue  in  4 each  background colour, aligned with DrawX/DrawY
- rom_addr  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr changes (synchronous posedge ROM)
- pal_index  out  IDX_W  equals rom_q, drives external palette
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index, combinational
- red, green, blue  out  4 each  registered pixel colour
- hit  out  1  registered; pixel in the current red/green/blue is inside the sprite box

## Operation
- Frame start is DrawX==0 && DrawY==0. On that cycle:
  - Shadow registers latch pos_x, pos_y and scale.
  - The animation logic updates.
  - Pixel (0,0) still uses the old shadow values. New values apply from the next pixel.
- Animation at frame start, when anim_en=1:
  - hold_cnt increments.
  - When hold_cnt reaches HOLD-1, it wraps to 0 and anim_frame advances, wrapping FRAMES-1 to 0.
  - When anim_en=0, both counters freeze.
  - With FRAMES=1, anim_frame stays 0.
- Stage 0 (combinational, registered into stage 1):
  - Extents ext_w = SPR_W<<scale and ext_h = SPR_H<<scale, computed in 13 bits.
  - in_box = blank && DrawX >= sx && DrawX < sx+ext_w && DrawY >= sy && DrawY < sy+ext_h.
  - Comparisons use 13-bit unsigned arithmetic. The box clips at screen edges and never wraps.
  - u = (DrawX-sx)>>scale and v = (DrawY-sy)>>scale.
  - addr = anim_frame*SPR_W*SPR_H + v*SPR_W + u.
  - rom_addr <= in_box ? addr : 0.
- Stage 1 registers: hit1, blank1 and bg1 (background colour).
- Stage 2 (rom_q valid):
  - Registers hit2, blank2 and bg2.
  - Captures the palette colour for rom_q.
- Output register:
  - If !blank2, output 0.
  - Else if hit2 && rom_q != TRANSP_IDX, output the palette colour.
  - Else output bg2.
  - hit follows hit2.
- No combinational path from any input to red, green, blue or hit.

## Timing
- Latency is 3 cycles: inputs at edge t appear on red/green/blue/hit after edge t+3. rom_addr appears after edge t+1.
- Fully pipelined, one pixel per cycle, no stalls.
- Reset (reset_n=0 at a posedge) clears all of the following:
  - Outputs: rom_addr, red, green, blue and hit are 0.
  - Shadows: pos 0, scale 0.
  - Animation: anim_frame 0, hold_cnt 0.
  - All pipeline valid/blank bits are 0.
- Reset mid-frame: outputs are 0 for the reset cycle plus the 3 pipeline cycles after release. Shadows stay at 0 until the next frame start.
- Simultaneous frame start and anim_en rising: the advance counts on that same cycle.
- pos_x/pos_y/scale changes mid-frame have no effect until the next frame start.

## Test plan
- Reset: hold reset_n=0 for 4 cycles with random inputs. Required: red/green/blue=0, hit=0 and rom_addr=0 throughout and for 3 cycles after release.
- Placement, scale 0: set pos (100,50), ROM model index = addr[1:0], TRANSP_IDX=0, background 4'h3. Required:
  - Pixel (99,50) shows the background.
  - Pixel (100,50) has rom_addr 0, hit=1 and shows the palette colour for index 0 only if not transparent.
  - Pixel (101,51) has rom_addr 56.
  - Pixel (155,50) has hit=0.
- Transparency: ROM returns 0 everywhere inside the box. Required: hit=1 but output equals bg after 3 cycles. With ROM returning 2, output equals pal colour 2.
- Scale 2: pos (0,0). Required:
  - The box spans x 0..219.
  - Pixels (3,0) and (4,0) give rom_addr 0 and 1.
  - Pixel (219,0) gives rom_addr 54; pixel (220,0) gives hit=0.
  - Position 600 clips at 639 with no wrap to x=0.
- Mid-frame update: change pos_x from 100 to 200 at DrawY=100. Required: the box stays at 100 for the rest of the frame and moves to 200 from pixel (1,0) of the next frame.
- Animation: FRAMES=3, HOLD=2, anim_en=1. Required:
  - Frame base address at pixel (sx,sy) follows 0, 0, 3025, 3025, 6050, 6050, 0 over successive frames.
  - Dropping anim_en freezes the base.
  - Blank=0 inside the box forces output 0.
